// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared constants and helpers for the PDM transmit path.
// The LFSR constants are only used when PDM_TX_DITHER_EN is defined.
package pdm_pkg;

    localparam int PCM_WIDTH_DEF  = 16;
    localparam int OVERSAMPLE_DEF = 64;

    typedef logic [15:0] lfsr_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0].
    localparam lfsr_t LFSR_SEED = 16'hACE1;
    localparam lfsr_t LFSR_TAPS = 16'hB400;

    // Two's complement to offset binary: flip the sign bit of a w-bit value.
    function automatic logic [31:0] to_offset_binary(input logic [31:0] s, input int unsigned w);
        return s ^ (32'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/pdm_dsm_core.sv
// rtl/pdm_dsm_core.sv - first-order delta-sigma accumulator with registered carry output.
// PDM_TX_DITHER_EN adds an LFSR whose bit 0 drives the accumulator carry-in.
module pdm_dsm_core
    import pdm_pkg::*;
#(
    parameter int W = PCM_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         clear,
    input  logic [W-1:0] u,
    output logic         pdm
);

    logic [W-1:0] acc_q, acc_d;
    logic         pdm_q, pdm_d;
    logic         cin;
    logic [W:0]   sum;

`ifdef PDM_TX_DITHER_EN
    lfsr_t lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (clear) begin
            lfsr_d = LFSR_SEED;
        end else if (step) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign cin = lfsr_q[0];
`else
    assign cin = 1'b0;
`endif

    // The carry out of the W+1-bit sum is the PDM bit for this strobe.
    assign sum = {1'b0, acc_q} + {1'b0, u} + {{W{1'b0}}, cin};

    always_comb begin
        acc_d = acc_q;
        pdm_d = pdm_q;
        if (clear) begin
            acc_d = '0;
            pdm_d = 1'b0;
        end else if (step) begin
            acc_d = sum[W-1:0];
            pdm_d = sum[W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            pdm_q <= pdm_d;
        end
    end

    assign pdm = pdm_q;

endmodule

// File: rtl/pdm_tx_modulator.sv
// rtl/pdm_tx_modulator.sv - PCM-to-PDM transmitter with one-entry sample holding buffer.
// Optional dither via PDM_TX_DITHER_EN (handled inside pdm_dsm_core).
module pdm_tx_modulator
    import pdm_pkg::*;
#(
    parameter int PCM_WIDTH  = PCM_WIDTH_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m_clk_rising,
    input  logic                 en,
    input  logic [PCM_WIDTH-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 pdm_data,
    output logic                 sample_tick,
    output logic                 underrun
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [PCM_WIDTH-1:0] active_q, active_d;
    logic [PCM_WIDTH-1:0] pend_q, pend_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 sample_tick_q, sample_tick_d;
    logic                 underrun_q, underrun_d;

    logic                 step;
    logic                 boundary;
    logic                 xfer;
    logic [31:0]          u_wide;
    logic                 unused_u_hi;

    assign step     = m_clk_rising & en;
    assign boundary = step && (bit_cnt_q == LAST_BIT);
    assign xfer     = s_valid && !pend_valid_q;

    assign u_wide      = to_offset_binary(32'(active_q), PCM_WIDTH);
    assign unused_u_hi = ^u_wide[31:PCM_WIDTH];

    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        active_d      = active_q;
        pend_d        = pend_q;
        pend_valid_d  = pend_valid_q;
        sample_tick_d = 1'b0;
        underrun_d    = 1'b0;

        if (!en) begin
            bit_cnt_d = '0;
        end else if (step) begin
            bit_cnt_d = boundary ? '0 : bit_cnt_q + CNT_W'(1);
        end

        // The load sees only the pre-edge buffer state; a same-cycle write waits for the next boundary.
        if (boundary) begin
            if (pend_valid_q) begin
                active_d      = pend_q;
                pend_valid_d  = 1'b0;
                sample_tick_d = 1'b1;
            end else begin
                underrun_d = 1'b1;
            end
        end

        if (xfer) begin
            pend_d       = s_data;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q     <= '0;
            active_q      <= '0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            sample_tick_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            active_q      <= active_d;
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            sample_tick_q <= sample_tick_d;
            underrun_q    <= underrun_d;
        end
    end

    pdm_dsm_core #(
        .W (PCM_WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .step  (step),
        .clear (!en),
        .u     (u_wide[PCM_WIDTH-1:0]),
        .pdm   (pdm_data)
    );

    assign s_ready     = !pend_valid_q;
    assign sample_tick = sample_tick_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_pdm_tx_modulator.sv
// tb/tb_pdm_tx_modulator.sv - self-checking bench for pdm_tx_modulator (dither macro undefined).
module tb_pdm_tx_modulator;

    localparam int W  = 16;
    localparam int OS = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         m_clk_rising;
    logic         en;
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic         pdm_data;
    logic         sample_tick;
    logic         underrun;

    always #5 clk = ~clk;

    pdm_tx_modulator #(
        .PCM_WIDTH  (W),
        .OVERSAMPLE (OS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_clk_rising (m_clk_rising),
        .en           (en),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .pdm_data     (pdm_data),
        .sample_tick  (sample_tick),
        .underrun     (underrun)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: the output bit is the change in floor(S / 2^W), S = running sum of u since clear.
    longint       m_sum;
    int           m_pos;
    logic [W-1:0] m_active;
    logic [W-1:0] m_pend;
    bit           m_pend_v;
    bit           e_pdm, e_tick, e_under;

    int n_tick, n_under, n_ones, n_strobes;

    typedef struct {
        logic [W-1:0] sample;
        int           ones;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sum    = 0;
        m_pos    = 0;
        m_active = '0;
        m_pend   = '0;
        m_pend_v = 0;
        e_pdm    = 0;
        e_tick   = 0;
        e_under  = 0;
    endtask

    task automatic clear_stats();
        n_tick    = 0;
        n_under   = 0;
        n_ones    = 0;
        n_strobes = 0;
    endtask

    task automatic cycle();
        bit     xfer;
        bit     strobe;
        longint u, ns;
        xfer   = s_valid && !m_pend_v;
        strobe = m_clk_rising && en && !rst;
        if (rst) begin
            model_reset();
        end else begin
            e_tick  = 0;
            e_under = 0;
            if (!en) begin
                m_sum = 0;
                m_pos = 0;
                e_pdm = 0;
            end else if (m_clk_rising) begin
                u     = longint'(m_active ^ 16'h8000);
                ns    = m_sum + u;
                e_pdm = ((ns >> W) != (m_sum >> W));
                m_sum = ns;
                if (m_pos == OS - 1) begin
                    m_pos = 0;
                    if (m_pend_v) begin
                        m_active = m_pend;
                        m_pend_v = 0;
                        e_tick   = 1;
                    end else begin
                        e_under = 1;
                    end
                end else begin
                    m_pos++;
                end
            end
            if (xfer) begin
                m_pend   = s_data;
                m_pend_v = 1;
            end
        end
        @(posedge clk);
        #1;
        check("pdm_data", 64'(pdm_data), 64'(e_pdm));
        check("sample_tick", 64'(sample_tick), 64'(e_tick));
        check("underrun", 64'(underrun), 64'(e_under));
        check("s_ready", 64'(s_ready), 64'(!m_pend_v));
        if (sample_tick === 1'b1) n_tick++;
        if (underrun === 1'b1) n_under++;
        if (strobe) begin
            n_strobes++;
            if (pdm_data === 1'b1) n_ones++;
        end
    endtask

    task automatic strobes(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            m_clk_rising = 1'b0;
            repeat (gap - 1) cycle();
            m_clk_rising = 1'b1;
            cycle();
            m_clk_rising = 1'b0;
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        cycle();
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        en           = 1'b0;
        s_valid      = 1'b0;
        m_clk_rising = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] smp[3];
        int           tick_pos[8];
        int           nt;
        int           idx;
        bit           xfer_now;
        bit           found;

        rst          = 1'b1;
        en           = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        m_clk_rising = 1'b0;
        model_reset();
        clear_stats();

        vecs[0] = '{16'h8000, 0};
        vecs[1] = '{16'h4000, 48};
        vecs[2] = '{16'h0000, 32};
        vecs[3] = '{16'hC000, 16};
        vecs[4] = '{16'h7FFF, 63};

        // Reset state and idle midscale with slow strobes.
        do_reset();
        check("reset_pdm", 64'(pdm_data), 64'd0);
        check("reset_tick", 64'(sample_tick), 64'd0);
        check("reset_underrun", 64'(underrun), 64'd0);
        check("reset_ready", 64'(s_ready), 64'd1);
        en = 1'b1;
        clear_stats();
        strobes(130, 50);
        check("idle_ones", 64'(n_ones), 64'd65);
        check("idle_underruns", 64'(n_under), 64'd2);
        check("idle_ticks", 64'(n_tick), 64'd0);

        // Window density table: each sample loaded at a boundary, ones counted over its window.
        do_reset();
        en = 1'b1;
        push(vecs[0].sample);
        clear_stats();
        strobes(OS, 3);
        check("first_boundary_tick", 64'(n_tick), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i + 1 < 5) push(vecs[i + 1].sample);
            clear_stats();
            strobes(OS, 2);
            check($sformatf("window_ones_%0d", i), 64'(n_ones), 64'(vecs[i].ones));
            check($sformatf("window_tick_%0d", i), 64'(n_tick), (i + 1 < 5) ? 64'd1 : 64'd0);
            check($sformatf("window_underrun_%0d", i), 64'(n_under), (i + 1 < 5) ? 64'd0 : 64'd1);
        end

        // Back-to-back samples with s_valid held.
        do_reset();
        en     = 1'b1;
        smp[0] = 16'h1234;
        smp[1] = 16'hA5A5;
        smp[2] = 16'h7000;
        idx    = 0;
        nt     = 0;
        s_valid = 1'b1;
        s_data  = smp[0];
        clear_stats();
        for (int c = 0; c < OS * 3 * 2; c++) begin
            xfer_now     = s_valid && !m_pend_v;
            m_clk_rising = (c % 2 == 1);
            cycle();
            if (c == 0) check("hold_first_accept", 64'(s_ready), 64'd0);
            if (xfer_now) begin
                idx++;
                if (idx < 3) s_data = smp[idx];
                else s_valid = 1'b0;
            end
            if (sample_tick === 1'b1 && nt < 8) begin
                tick_pos[nt] = n_strobes;
                nt++;
            end
        end
        m_clk_rising = 1'b0;
        s_valid      = 1'b0;
        check("hold_ticks", 64'(n_tick), 64'd3);
        check("hold_underruns", 64'(n_under), 64'd0);
        if (nt >= 3) begin
            check("hold_gap_1", 64'(tick_pos[1] - tick_pos[0]), 64'd64);
            check("hold_gap_2", 64'(tick_pos[2] - tick_pos[1]), 64'd64);
        end

        // Disable mid-window, then re-enable: fresh period of OS strobes.
        do_reset();
        en = 1'b1;
        push(16'h2000);
        strobes(20, 2);
        en = 1'b0;
        strobes(10, 2);
        check("disabled_pdm", 64'(pdm_data), 64'd0);
        check("disabled_ready", 64'(s_ready), 64'd0);
        en    = 1'b1;
        found = 0;
        for (int i = 1; i <= 200 && !found; i++) begin
            strobes(1, 2);
            if (sample_tick === 1'b1 || underrun === 1'b1) begin
                found = 1;
                check("reenable_boundary_strobes", 64'(i), 64'd64);
                check("reenable_tick", 64'(sample_tick), 64'd1);
            end
        end
        if (!found) check("reenable_boundary_timeout", 64'd0, 64'd1);

        // Reset pulsed mid-window with a strobe and a handshake in flight.
        push(16'h1111);
        strobes(5, 2);
        rst          = 1'b1;
        m_clk_rising = 1'b1;
        s_valid      = 1'b1;
        s_data       = 16'h5555;
        cycle();
        rst          = 1'b0;
        m_clk_rising = 1'b0;
        s_valid      = 1'b0;
        check("midreset_pdm", 64'(pdm_data), 64'd0);
        check("midreset_tick", 64'(sample_tick), 64'd0);
        check("midreset_underrun", 64'(underrun), 64'd0);
        check("midreset_ready", 64'(s_ready), 64'd1);
        clear_stats();
        strobes(OS, 2);
        check("midreset_boundary_underrun", 64'(n_under), 64'd1);
        check("midreset_boundary_tick", 64'(n_tick), 64'd0);
        check("midreset_ones", 64'(n_ones), 64'd32);

        // Randomized traffic against the reference model.
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            m_clk_rising = ($urandom_range(0, 2) == 0);
            s_valid      = ($urandom_range(0, 3) == 0);
            s_data       = W'($urandom);
            en           = ($urandom_range(0, 299) != 0);
            rst          = ($urandom_range(0, 1499) == 0);
            cycle();
        end
        rst          = 1'b0;
        en           = 1'b0;
        s_valid      = 1'b0;
        m_clk_rising = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pdm_tx_modulator.md
Name: pdm_tx_modulator

Overview:
- PCM-to-PDM transmitter: first-order delta-sigma modulator that turns signed PCM samples into a 1-bit PDM stream.
- Paced by the PDM clock generator's rising strobe. Acts as the microphone end of the PDM link.
- Used as the loopback/stimulus source for the PDM capture path and as an on-fabric mic emulator.
- Accepts samples over a valid/ready stream with a one-entry holding buffer.

Parameters:
- PCM_WIDTH, 16, width of signed PCM input sample.
- OVERSAMPLE, 64, PDM bits emitted per PCM sample (decimation ratio); must be ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- m_clk_rising  in  1  one-clk strobe from the PDM clock generator, one per PDM bit period.
- en  in  1  modulator enable.
- s_data  in  PCM_WIDTH  signed PCM sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  holding register empty.
- pdm_data  out  1  registered PDM bit.
- sample_tick  out  1  one-clk pulse when a new sample becomes active.
- underrun  out  1  one-clk pulse when a sample boundary finds the holding register empty.

Behaviour:
- Reset values:
  - pdm_data=0, sample_tick=0, underrun=0, s_ready=1 (after reset).
  - acc=0, bit_cnt=0, active=0 (midscale), pend_valid=0.
- Handshake:
  - s_ready = !pend_valid.
  - Transfer on s_valid&&s_ready sets pend_valid=1 and pend=s_data.
  - s_data is ignored when s_ready=0.
- Strobe step (m_clk_rising=1 && en=1):
  - u = active XOR MSB (offset binary, PCM_WIDTH bits).
  - {carry, acc} <= acc + u, in PCM_WIDTH+1-bit arithmetic; pdm_data <= carry.
  - pdm_data changes on the clk edge after the strobe cycle (latency 1 clk); holds between strobes.
  - bit_cnt increments, wrapping at OVERSAMPLE-1 → 0.
- Sample boundary (strobe step with bit_cnt==OVERSAMPLE-1):
  - pend_valid=1: active<=pend, pend_valid<=0, sample_tick pulse.
  - pend_valid=0: active unchanged (repeat last sample), underrun pulse, no sample_tick.
  - The new active value applies from the next strobe.
- Simultaneous transfer and boundary in the same cycle with pend_valid=0: the write is not visible to the load. The result is underrun, and the incoming sample lands in pend for the next boundary. No bypass.
- en=0:
  - acc, bit_cnt and pdm_data cleared to 0 synchronously; strobes ignored.
  - active and pend retained; handshake still operates.
  - On re-enable the next strobe is bit 0 of a fresh period.
- Reset mid-operation: all state returns to reset values on the next clk, regardless of strobe or handshake.
- Density: the ones count over any 2^PCM_WIDTH strobes equals u exactly. Midscale alternates 0,1,0,1.

Optional Feature:
- Macro PDM_TX_DITHER_EN.
- Defined: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1 on reset and on en=0.
  - Advances once per strobe step.
  - Its bit 0 is the carry-in of the accumulator add; this breaks idle tones.
- Not defined: carry-in is 0 and the output is fully deterministic, as specified above.
- Test Plan values below assume the macro is not defined.

Decomposition:
- Package pdm_pkg:
  - PCM_WIDTH default, OVERSAMPLE default.
  - LFSR seed/taps constants.
  - Offset-binary conversion function.
- Natural sub-module: pdm_dsm_core.
  - Contains the accumulator, carry output and optional LFSR, with step/clear inputs.
  - The top level holds the handshake, holding register and bit counter.

Test Plan:
- Reset, en=1, no samples, strobe every 50 clk:
  - pdm_data sequence 0,1,0,1…
  - underrun pulse every 64th strobe; sample_tick never asserts.
- Push 0x7FFF before the first boundary:
  - sample_tick at boundary 1.
  - The next 64 bits contain 63 ones.
  - underrun at boundary 2.
- Push 0x8000 (most negative): the following 64-bit window is all zeros.
- Push 0x4000 (u=0xC000): exactly 48 ones in the 64-bit window.
- Hold s_valid with 3 samples:
  - First accepted immediately; s_ready=0 until each boundary.
  - Three consecutive sample_tick pulses 64 strobes apart, no underrun.
- Mid-stream, deassert en for 10 strobes, then reassert:
  - pdm_data=0 while disabled.
  - Output restarts from acc=0; the next boundary is 64 strobes after re-enable.
  - Repeat with rst pulsed mid-window: every output returns to its reset value.
